// File: rtl/stack_based_alu.sv
// LIFO operand stack with a signed add/multiply ALU.
// Results and overflow are registered; empty/full decode the pointer.
module stack_based_alu #(
  parameter int n     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] input_data,
  input  logic [2:0]   opcode,
  output logic [n-1:0] output_data,
  output logic         overflow,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [n-1:0]   mem [DEPTH];
  logic [PW-1:0]  sp;
  logic [AW-1:0]  top_idx;
  logic [AW-1:0]  nxt_idx;
  logic [AW-1:0]  wr_idx;
  logic [n-1:0]   top;
  logic [n-1:0]   nxt;
  logic [n-1:0]   sum;
  logic [2*n-1:0] top_x;
  logic [2*n-1:0] nxt_x;
  logic [2*n-1:0] prod;
  logic [n:0]     prod_hi;
  logic           add_ovf;
  logic           mul_ovf;
  logic           two;
  logic           do_add;
  logic           do_mul;
  logic           do_push;
  logic           do_pop;

  assign empty   = (sp == '0);
  assign full    = (sp == PW'(DEPTH));
  assign two     = (sp >= PW'(2));

  assign top_idx = AW'(sp - PW'(1));
  assign nxt_idx = AW'(sp - PW'(2));
  assign wr_idx  = AW'(sp);
  assign top     = mem[top_idx];
  assign nxt     = mem[nxt_idx];

  assign sum     = top + nxt;
  assign add_ovf = (top[n-1] == nxt[n-1]) &&
                   (sum[n-1] != top[n-1]);

  // Sign-extended operands make the low 2n bits the signed product.
  assign top_x   = {{n{top[n-1]}}, top};
  assign nxt_x   = {{n{nxt[n-1]}}, nxt};
  assign prod    = top_x * nxt_x;
  assign prod_hi = prod[2*n-1:n-1];
  assign mul_ovf = !((&prod_hi) || !(|prod_hi));

  assign do_add  = (opcode == 3'b100) && two;
  assign do_mul  = (opcode == 3'b101) && two;
  assign do_push = (opcode == 3'b110) && !full;
  assign do_pop  = (opcode == 3'b111) && !empty;

  // Stack, pointer and registered ALU results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp          <= '0;
      output_data <= '0;
      overflow    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (1'b1)
        do_add: begin
          output_data <= sum;
          overflow    <= add_ovf;
        end
        do_mul: begin
          output_data <= prod[n-1:0];
          overflow    <= mul_ovf;
        end
        do_push: begin
          mem[wr_idx] <= input_data;
          sp          <= sp + PW'(1);
        end
        do_pop: begin
          sp          <= sp - PW'(1);
          output_data <= top;
          overflow    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_based_alu.sv
// Self-checking bench for stack_based_alu.
// Directed plan steps followed by random ops against a queue model.
module tb_stack_based_alu;

  localparam int N = 8;
  localparam int D = 8;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] ADD  = 3'b100;
  localparam logic [2:0] MUL  = 3'b101;
  localparam logic [2:0] PUSH = 3'b110;
  localparam logic [2:0] POP  = 3'b111;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] input_data = '0;
  logic [2:0]   opcode = NOP;
  logic [N-1:0] output_data;
  logic         overflow;
  logic         empty;
  logic         full;

  int compared = 0;
  int mismatched = 0;

  logic [N-1:0] q[$];
  logic [N-1:0] m_out = '0;
  logic         m_ovf = 1'b0;

  stack_based_alu #(.n(N), .DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .input_data(input_data),
    .opcode(opcode),
    .output_data(output_data),
    .overflow(overflow),
    .empty(empty),
    .full(full)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out"}, 32'(output_data), 32'(m_out));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == D));
  endtask

  task automatic model(input logic [2:0] oc,
                       input logic [N-1:0] d);
    int a;
    int b;
    int r;
    logic [31:0] rv;
    case (oc)
      PUSH: if (q.size() < D) q.push_back(d);
      POP: if (q.size() > 0) begin
        m_out = q.pop_back();
        m_ovf = 1'b0;
      end
      ADD, MUL: if (q.size() >= 2) begin
        a = int'($signed(q[q.size()-1]));
        b = int'($signed(q[q.size()-2]));
        r = (oc == ADD) ? a + b : a * b;
        rv = r;
        m_out = rv[N-1:0];
        m_ovf = (r > 127) || (r < -128);
      end
      default: ;
    endcase
  endtask

  task automatic op(input logic [2:0] oc,
                    input logic [N-1:0] d);
    @(negedge clk);
    opcode = oc;
    input_data = d;
    @(posedge clk);
    #1;
    model(oc, d);
    chk_all($sformatf("op%0b", oc));
  endtask

  task automatic do_reset();
    @(negedge clk);
    opcode = NOP;
    rst = 1'b1;
    q.delete();
    m_out = '0;
    m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("reset");
  endtask

  initial begin
    do_reset();

    op(PUSH, 8'd10);
    op(PUSH, 8'd20);
    op(ADD, 8'h00);
    chk("add30", 32'(output_data), 32'h1E);
    chk("depth2", 32'(q.size()), 32'd2);
    op(PUSH, 8'd3);
    op(PUSH, 8'd4);
    op(MUL, 8'h00);
    chk("mul12", 32'(output_data), 32'd12);
    op(POP, 8'h00);
    chk("pop4", 32'(output_data), 32'd4);

    do_reset();
    op(PUSH, 8'h7F);
    op(PUSH, 8'h01);
    op(ADD, 8'h00);
    chk("add80", 32'(output_data), 32'h80);
    chk("add80v", 32'(overflow), 32'd1);
    op(PUSH, 8'h80);
    op(PUSH, 8'hFF);
    op(ADD, 8'h00);
    chk("add7f", 32'(output_data), 32'h7F);
    chk("add7fv", 32'(overflow), 32'd1);

    do_reset();
    op(PUSH, 8'h80);
    op(PUSH, 8'h02);
    op(MUL, 8'h00);
    chk("mul00", 32'(output_data), 32'h00);
    chk("mul00v", 32'(overflow), 32'd1);
    op(PUSH, 8'hFF);
    op(PUSH, 8'h02);
    op(MUL, 8'h00);
    chk("mulfe", 32'(output_data), 32'hFE);
    chk("mulfev", 32'(overflow), 32'd0);

    do_reset();
    op(POP, 8'h00);
    op(ADD, 8'h00);
    op(MUL, 8'h00);
    chk("empty0", 32'(output_data), 32'd0);
    chk("empty1", 32'(empty), 32'd1);
    for (int i = 0; i < D; i++) begin
      op(PUSH, 8'(8'h30 + i));
    end
    chk("full1", 32'(full), 32'd1);
    op(PUSH, 8'hEE);
    op(POP, 8'h00);
    chk("pop8th", 32'(output_data), 32'h37);

    op(PUSH, 8'h11);
    op(PUSH, 8'h22);
    op(POP, 8'h00);
    @(negedge clk);
    opcode = PUSH;
    input_data = 8'h44;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.out", 32'(output_data), 32'd0);
    chk("arst.ovf", 32'(overflow), 32'd0);
    chk("arst.empty", 32'(empty), 32'd1);
    chk("arst.full", 32'(full), 32'd0);
    q.delete();
    m_out = '0;
    m_ovf = 1'b0;
    opcode = NOP;
    @(negedge clk);
    rst = 1'b0;
    op(POP, 8'h00);
    op(PUSH, 8'h05);
    op(PUSH, 8'hFB);
    op(ADD, 8'h00);
    chk("post.add", 32'(output_data), 32'h00);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] oc;
      logic [N-1:0] d;
      int sel;
      sel = $urandom_range(0, 9);
      d = 8'($urandom);
      if (sel < 4) oc = PUSH;
      else if (sel < 6) oc = POP;
      else if (sel == 6) oc = ADD;
      else if (sel == 7) oc = MUL;
      else oc = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) do_reset();
      else op(oc, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
